// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_ctrl_pkg;

    // Access sequencing: request accepted in IDLE, two half-word phases, one release cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // CPU byte address that maps to SRAM half-word 0.
    localparam int unsigned DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response bundle between the pipeline and the SRAM controller.
// Latency: n/a (wires only).
// Backpressure: ready=0 tells the pipeline to freeze and hold its request stable.
// Ports: wr_en/rd_en/address/write_data from the MEM stage; read_data/ready back to it.
interface sram_mem_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1, flags the final cycle of a phase.
// Latency: last is combinational from the registered count.
// Backpressure: none; clear has priority over en.
// Ports: clk, rst (async, active-high), clear, en in; last out.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign last = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data-memory responder: one 32-bit access = two 16-bit async-SRAM accesses (low half first).
// Latency: ready low for 2*WAIT_CYCLES+1 cycles per access, high in DONE; read_data valid from DONE.
// Backpressure: ready=0 freezes the pipeline; requests must be held stable until ready returns.
// Ports: clk, rst (async, active-high); mem (slave modport); sram_* pins to the external SRAM.
// Optional: define SRAM_MEM_CTRL_STATS_EN to add saturating rd_count/wr_count outputs.
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_mem_controller_if.slave   mem,
    inout  wire  [15:0]            sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
`ifdef SRAM_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
`endif
);

    state_t state_q, state_d;
    op_t    op_q, op_d;

    logic cnt_clear, cnt_en, cnt_last;
    logic req;
    logic wr_drive;
    logic phase_end_rd;

    logic [SRAM_ADDR_W-2:0] word;
    logic [SRAM_ADDR_W-1:0] addr_lo, addr_hi;
    logic [SRAM_ADDR_W-1:0] sram_addr_q;
    logic [15:0]            lo_reg;
    logic [31:0]            read_data_q;

    assign req = mem.wr_en | mem.rd_en;

    // Word index relative to the SRAM window; upper bits beyond the SRAM are dropped.
    assign word    = (SRAM_ADDR_W-1)'((mem.address - 32'(BASE_ADDR)) >> 2);
    assign addr_lo = {word, 1'b0};
    assign addr_hi = {word, 1'b1};

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .last  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d   = LOW;
                    cnt_clear = 1'b1;
                    // A store takes precedence when both enables are raised.
                    op_d      = mem.wr_en ? OP_WR : OP_RD;
                end
            end
            LOW: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d   = HIGH;
                    cnt_clear = 1'b1;
                end
            end
            HIGH: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d   = DONE;
                    cnt_clear = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign phase_end_rd = cnt_last && (op_q == OP_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            sram_addr_q <= '0;
            lo_reg      <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            // Address is loaded on phase entry so it is stable for the whole phase and holds afterwards.
            if (state_q == IDLE && req) begin
                sram_addr_q <= addr_lo;
            end else if (state_q == LOW && cnt_last) begin
                sram_addr_q <= addr_hi;
            end
            // Sample dq at the end of each phase, after the SRAM access time has elapsed.
            if (state_q == LOW && phase_end_rd) begin
                lo_reg <= sram_dq;
            end
            if (state_q == HIGH && phase_end_rd) begin
                read_data_q <= {sram_dq, lo_reg};
            end
        end
    end

`ifdef SRAM_MEM_CTRL_STATS_EN
    logic [15:0] rd_count_q, wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == HIGH && cnt_last) begin
            if (op_q == OP_RD && rd_count_q != 16'hFFFF) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (op_q == OP_WR && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

    assign wr_drive = (op_q == OP_WR) && (state_q == LOW || state_q == HIGH);

    assign sram_we_n = ~wr_drive;
    assign sram_dq   = wr_drive ? ((state_q == HIGH) ? mem.write_data[31:16] : mem.write_data[15:0])
                                : 16'hzzzz;
    assign sram_addr = sram_addr_q;

    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    assign mem.read_data = read_data_q;
    assign mem.ready     = (state_q == IDLE && !req) || (state_q == DONE);

endmodule
